// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed program loader writing instruction RAM
// Holds the CPU in reset until a length-checked, XOR-verified image is resident.
module program_loader #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int BASE_ADDR    = 0,
  parameter bit USE_CHECKSUM = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W+1:0] MAX_LEN = (ADDR_W+2)'(2**ADDR_W - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state;
  state_t              next_state;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     idx_q;
  logic [DATA_W-1:0]   acc_q;

  logic                xfer;
  logic [ADDR_W:0]     len_in;
  logic                len_bad;
  logic                last_word;
  logic                start_ok;

  logic                in_ready_d;
  logic                ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_d;
  logic                cpu_reset_d;
  logic                busy_d;
  logic                done_d;
  logic                error_d;
  logic [ADDR_W:0]     words_d;
  logic [ADDR_W:0]     len_d;
  logic [ADDR_W:0]     idx_d;
  logic [DATA_W-1:0]   acc_d;

  // in_ready is only ever high in LEN/LOAD/CHECK, so a transfer never meets start
  assign xfer      = in_valid & in_ready;
  assign len_in    = in_data[ADDR_W:0];
  assign len_bad   = (len_in == '0) || ({1'b0, len_in} > MAX_LEN);
  assign last_word = (idx_q == len_q - ONE);
  assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) next_state = S_LEN;
      end
      S_LEN: begin
        if (xfer) next_state = len_bad ? S_ERROR : S_LOAD;
      end
      S_LOAD: begin
        if (xfer && last_word) next_state = USE_CHECKSUM ? S_CHECK : S_DONE;
      end
      S_CHECK: begin
        if (xfer) next_state = (in_data == acc_q) ? S_DONE : S_ERROR;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and session counters
  always_comb begin
    in_ready_d  = (next_state == S_LEN) || (next_state == S_LOAD) || (next_state == S_CHECK);
    busy_d      = in_ready_d;
    done_d      = (next_state == S_DONE);
    error_d     = (next_state == S_ERROR);
    // the CPU leaves reset only after a full DONE cycle, so the last write has landed
    cpu_reset_d = !(state == S_DONE && next_state == S_DONE);
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    words_d     = words_loaded;
    len_d       = len_q;
    idx_d       = idx_q;
    acc_d       = acc_q;

    if (start_ok) begin
      words_d = '0;
      idx_d   = '0;
      acc_d   = '0;
    end

    if (state == S_LEN && xfer && !len_bad) begin
      len_d = len_in;
    end

    if (state == S_LOAD && xfer) begin
      ram_we_d    = 1'b1;
      ram_addr_d  = BASE_A + idx_q[ADDR_W-1:0];
      ram_wdata_d = in_data;
      words_d     = idx_q + ONE;
      idx_d       = idx_q + ONE;
      acc_d       = acc_q ^ in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready     <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      cpu_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
    end else begin
      in_ready     <= in_ready_d;
      ram_we       <= ram_we_d;
      ram_addr     <= ram_addr_d;
      ram_wdata    <= ram_wdata_d;
      cpu_reset    <= cpu_reset_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      words_loaded <= words_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
    end
  end

endmodule
